sram_read_streamer: RTL

- Read-side initiator for the single-port byte-masked SRAM macro. Given a base address and word count, it issues back-to-back read requests on the SRAM control/data pins and absorbs the SRAM's 1-cycle registered read latency.
- Read words are delivered on a valid/ready stream with full backpressure support.
- Sits between the layer controller and the SRAM, feeding activation/weight words to downstream compute.

---
 rtl/sram_read_streamer_if.sv | 28 ++
 rtl/sram_read_streamer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sram_read_streamer_if.sv
// Bus bundle between the read streamer, the SRAM macro pins and the downstream stream consumer.
// The master side is the streamer. The slave side is the SRAM plus the stream sink.
interface sram_read_streamer_if #(
  parameter int SRAM_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
);
  logic                  o_sram_active_low_en;
  logic                  o_sram_read_write_en;
  logic [SRAM_WIDTH-1:0] o_sram_write_bitmask;
  logic [SRAM_WIDTH-1:0] o_sram_data_in;
  logic [ADDR_WIDTH-1:0] o_sram_addr;
  logic [SRAM_WIDTH-1:0] i_sram_data_out;
  logic [SRAM_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;

  modport master (
    output o_sram_active_low_en, o_sram_read_write_en, o_sram_write_bitmask,
    output o_sram_data_in, o_sram_addr, o_data, o_valid,
    input  i_sram_data_out, i_ready
  );

  modport slave (
    input  o_sram_active_low_en, o_sram_read_write_en, o_sram_write_bitmask,
    input  o_sram_data_in, o_sram_addr, o_data, o_valid,
    output i_sram_data_out, i_ready
  );
endinterface

// File: rtl/sram_read_streamer.sv
// Streams i_count consecutive SRAM words, starting at i_base_addr, onto a valid/ready bus.
// A 2-entry skid FIFO absorbs the SRAM read latency. Reads are credited so that FIFO + in-flight <= 2.
module sram_read_streamer #(
  parameter int  DEPTH      = 64,
  parameter int  SRAM_WIDTH = 64,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_count,
  output logic                  o_busy,
  output logic                  o_done,
  sram_read_streamer_if.master  bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_issued;
  logic [ADDR_WIDTH:0]   r_popped;
  logic                  r_inflight;
  logic [SRAM_WIDTH-1:0] r_fifo [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_fifo_cnt;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [2:0]            w_credit;
  logic [ADDR_WIDTH:0]   w_popped_next;

  // Issue decision: credit counts words already owned after this cycle's pop
  always_comb begin
    w_pop         = (r_fifo_cnt != 2'd0) && bus.i_ready;
    w_push        = r_inflight;
    w_credit      = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue       = (r_state == ST_RUN) && (r_issued < r_count) && (w_credit < 3'd2);
    w_popped_next = r_popped + {{ADDR_WIDTH{1'b0}}, w_pop};
  end

  // SRAM pins and stream outputs
  always_comb begin
    bus.o_sram_active_low_en = ~w_issue;
    bus.o_sram_read_write_en = 1'b0;
    bus.o_sram_write_bitmask = {SRAM_WIDTH{1'b0}};
    bus.o_sram_data_in       = {SRAM_WIDTH{1'b0}};
    bus.o_sram_addr          = w_issue ? r_addr : {ADDR_WIDTH{1'b0}};
    bus.o_valid              = (r_fifo_cnt != 2'd0);
    bus.o_data               = r_fifo[r_rd_ptr];
    o_busy                   = (r_state != ST_IDLE);
    o_done                   = (r_state == ST_DONE);
  end

  // Control FSM, address walker and issue/pop counters
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state  <= ST_IDLE;
      r_addr   <= {ADDR_WIDTH{1'b0}};
      r_count  <= {(ADDR_WIDTH+1){1'b0}};
      r_issued <= {(ADDR_WIDTH+1){1'b0}};
      r_popped <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_addr   <= i_base_addr;
            r_count  <= i_count;
            r_issued <= {(ADDR_WIDTH+1){1'b0}};
            r_popped <= {(ADDR_WIDTH+1){1'b0}};
            r_state  <= (i_count == {(ADDR_WIDTH+1){1'b0}}) ? ST_DONE : ST_RUN;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_state <= (r_issued == r_count) ? ST_DRAIN : ST_RUN;
        end
        ST_DRAIN: begin
          // Leave on the final handshake so o_done lands on the very next cycle
          r_state <= (w_popped_next == r_count) ? ST_DONE : ST_DRAIN;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_issue) begin
        r_issued <= r_issued + {{ADDR_WIDTH{1'b0}}, 1'b1};
        r_addr   <= (r_addr == ADDR_WIDTH'(DEPTH - 1)) ? {ADDR_WIDTH{1'b0}}
                                                       : r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_popped <= w_popped_next;
      end
    end
  end

  // In-flight flag: the SRAM read data is valid exactly one cycle after an issue
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
    end
  end

  // Two-entry skid FIFO; push and pop in the same cycle leave the count unchanged
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_fifo[0]  <= {SRAM_WIDTH{1'b0}};
      r_fifo[1]  <= {SRAM_WIDTH{1'b0}};
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.i_sram_data_out;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule
